fab_issue_queue: RTL and testbench
==================================

Name: fab_issue_queue

Overview:
- In-order issue buffer between the decoder and the FAB execute stage.
- Accepts up to two decoded instructions per cycle (lane 0 older than lane 1) and holds them in a circular buffer.
- Presents one instruction per cycle to FAB with a valid/ready handshake.
- Tags each issued instruction with a 1-bit ordering number, and flushes all younger entries when FAB redirects the PC.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 4.
- PC_W, 32, PC width.
- DEC_W, 67, decode_out bundle width: InstType..RFWsrc as packed for FAB.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid0  in  1  lane 0 carries an instruction.
- in_valid1  in  1  lane 1 carries an instruction; legal only when in_valid0=1.
- in_pc0, in_pc1  in  PC_W  instruction PCs.
- in_npc0, in_npc1  in  PC_W  predicted next PCs.
- in_dec0, in_dec1  in  DEC_W  decode_out bundles.
- in_ready  out  1  at least two free entries.
- out_valid  out  1  head entry is presented.
- out_pc  out  PC_W  head PC to FAB pc.
- out_npc  out  PC_W  head npc to FAB npc.
- out_dec  out  DEC_W  head bundle to FAB decode_out.
- out_num  out  1  ordering number to FAB num_in.
- stop  in  1  FAB stalled; head is not consumed.
- flush  in  1  FAB branch_flag qualified by out_valid of the executing instruction.
- count  out  $clog2(DEPTH)+1  occupancy, for performance counters.

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, num counter=0; out_valid=0, in_ready=1; out_pc/out_npc/out_dec read entry 0, whose contents are don't-care; out_num=0. Storage is not cleared.
- Enqueue:
  - At a posedge with in_ready=1 and no flush, lane 0 is written at wr_ptr when in_valid0=1.
  - Lane 1 is written at wr_ptr+1 when in_valid1=1.
  - wr_ptr advances by in_valid0+in_valid1 (0, 1 or 2), modulo DEPTH.
  - in_valid with in_ready=0 is dropped. The decoder must hold its inputs, so the bench treats this as a protocol error.
  - in_valid1=1 with in_valid0=0 is a protocol error; the bench asserts it never occurs.
- Dequeue (pop): fires when out_valid=1, stop=0 and flush=0. rd_ptr advances by 1 and the num counter toggles.
- Head outputs:
  - out_* come combinationally from storage[rd_ptr]; out_valid = (count!=0).
  - Latency from an enqueue edge to out_valid=1 is 1 cycle (no bypass from empty).
- out_num: current num counter value. It alternates 0,1,0,... per issued instruction and gives FAB and writeback a relative order for same-cycle results.
- count_next = count + enq_n - pop, where enq_n = in_valid0+in_valid1 gated by in_ready.
- in_ready = (DEPTH - count) >= 2, evaluated from registered count, so there is no combinational path from in_valid.
- Simultaneous enqueue and pop: both apply in the same edge.
  - Full-minus-2 with enqueue of 2 and a pop gives count DEPTH-1.
- Full: count=DEPTH gives in_ready=0; pops continue.
- Empty: out_valid=0; stop is ignored; no pointer movement.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally.
  - A lane-1 write at wr_ptr=DEPTH-1 lands at index 0.
- Flush (highest priority): at the edge where flush=1:
  - rd_ptr and wr_ptr are set to 0 and count to 0.
  - The num counter is preserved.
  - Same-cycle enqueue and pop are discarded.
  - out_valid is 0 in the following cycle.
  - The decoder refetches from the FAB branch_address.
- stop=1 with flush=1: flush wins.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. Release is synchronised externally.

Decomposition:
- Shared package/header gets:
  - DEC_W and the decode_out field offsets already used by FAB.
  - An ISSUE_DEPTH constant.
  - PC reset value.
- One natural sub-module: fab_iq_mem, a DEPTH x (2*PC_W+DEC_W) register array with two write ports and one asynchronous read port.
  - No reset on the array.
  - Write collision is impossible because lane addresses differ by 1.
- Pointer, count, num and flush logic stay in fab_issue_queue.

Test Plan:
- Reset then single enqueue (pc=0x100, npc=0x104, in_valid0=1) -> next cycle out_valid=1, out_pc=0x100, out_num=0, count=1; pop with stop=0 -> count=0, out_valid=0.
- Dual enqueue pc0=0x200, pc1=0x204 with stop=1 for 3 cycles -> out_pc stays 0x200, count=2. Release stop -> issue order 0x200 (num 0) then 0x204 (num 1).
- Fill DEPTH=8 with four dual enqueues, stop=1 -> in_ready=0 from count=7. Further in_valid is dropped; count=8; after one pop, in_ready stays 0 (count=7). After a second pop, in_ready=1.
- Wrap: advance pointers to wr_ptr=7, then dual enqueue 0x300/0x304 -> entries 7 and 0. Issue order 0x300, 0x304 is preserved across the wrap.
- Flush with count=5 plus a same-cycle dual enqueue -> next cycle count=0, out_valid=0, num counter unchanged. The next enqueue (0x400) issues with the preserved num.
- Assert rst_n=0 between clock edges with count=3 -> out_valid=0, count=0, in_ready=1 immediately, before the next posedge.

Source files
------------

// File: rtl/fab_issue_queue_pkg.sv
// Shared constants for the FAB issue path: decode bundle layout, queue depth
// and the PC reset value.
package fab_issue_queue_pkg;

    // decode_out bundle width and field offsets, InstType at bit 0 up to RFWsrc
    localparam int FAB_DEC_W        = 67;
    localparam int DEC_INSTTYPE_LSB = 0;
    localparam int DEC_INSTTYPE_W   = 4;
    localparam int DEC_IMM_LSB      = 4;
    localparam int DEC_IMM_W        = 32;
    localparam int DEC_RS1_LSB      = 36;
    localparam int DEC_RS2_LSB      = 41;
    localparam int DEC_RD_LSB       = 46;
    localparam int DEC_REG_W        = 5;
    localparam int DEC_ALUOP_LSB    = 51;
    localparam int DEC_ALUOP_W      = 5;
    localparam int DEC_MEMOP_LSB    = 56;
    localparam int DEC_MEMOP_W      = 4;
    localparam int DEC_BRTYPE_LSB   = 60;
    localparam int DEC_BRTYPE_W     = 3;
    localparam int DEC_REGWRITE_LSB = 63;
    localparam int DEC_RFWSRC_LSB   = 64;
    localparam int DEC_RFWSRC_W     = 3;

    // Number of issue queue entries
    localparam int ISSUE_DEPTH = 8;

    // Fetch restart PC after reset
    localparam logic [31:0] PC_RESET = 32'h0000_0000;

endpackage

// File: rtl/fab_iq_mem.sv
// Issue queue storage: DEPTH entries, two write ports (decode lanes 0/1) and
// one asynchronous read port for the head entry. Contents are not reset.
module fab_iq_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 131
) (
    input  logic                     clk,
    input  logic                     we0,
    input  logic [$clog2(DEPTH)-1:0] waddr0,
    input  logic [W-1:0]             wdata0,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] waddr1,
    input  logic [W-1:0]             wdata1,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Lane writes; the two addresses always differ by one so never collide
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fab_issue_queue.sv
// In-order issue buffer between decode (two lanes per cycle) and the FAB
// execute stage (one instruction per cycle, valid/ready with stop).
// A FAB redirect (flush) empties the queue but keeps the ordering bit running.
module fab_issue_queue
    import fab_issue_queue_pkg::*;
#(
    parameter int DEPTH = ISSUE_DEPTH,
    parameter int PC_W  = 32,
    parameter int DEC_W = FAB_DEC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid0,
    input  logic                     in_valid1,
    input  logic [PC_W-1:0]          in_pc0,
    input  logic [PC_W-1:0]          in_pc1,
    input  logic [PC_W-1:0]          in_npc0,
    input  logic [PC_W-1:0]          in_npc1,
    input  logic [DEC_W-1:0]         in_dec0,
    input  logic [DEC_W-1:0]         in_dec1,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [PC_W-1:0]          out_npc,
    output logic [DEC_W-1:0]         out_dec,
    output logic                     out_num,
    input  logic                     stop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * PC_W + DEC_W;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          num_q;
    logic          we0;
    logic          we1;
    logic          pop;
    logic [1:0]    enq_n;
    logic [EW-1:0] head;

    // Ready depends only on registered occupancy, never on in_valid
    assign in_ready  = (count <= CW'(DEPTH - 2));
    assign out_valid = (count != '0);

    // Flush discards anything arriving or leaving on the same edge
    assign we0   = in_ready & in_valid0 & ~flush;
    assign we1   = in_ready & in_valid1 & ~flush;
    assign enq_n = {1'b0, we0} + {1'b0, we1};
    assign pop   = out_valid & ~stop & ~flush;

    fab_iq_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk    (clk),
        .we0    (we0),
        .waddr0 (wr_ptr),
        .wdata0 ({in_pc0, in_npc0, in_dec0}),
        .we1    (we1),
        .waddr1 (wr_ptr + AW'(1)),
        .wdata1 ({in_pc1, in_npc1, in_dec1}),
        .raddr  (rd_ptr),
        .rdata  (head)
    );

    assign {out_pc, out_npc, out_dec} = head;
    assign out_num = num_q;

    // Pointer, occupancy and ordering-bit state; flush empties but keeps num
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            num_q  <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(enq_n);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(enq_n) - CW'(pop);
            num_q  <= num_q ^ pop;
        end
    end

endmodule

// File: tb/tb_fab_issue_queue.sv
// Directed bench for fab_issue_queue (DEPTH=8, PC_W=32, DEC_W=67).
module tb_fab_issue_queue;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid0, in_valid1;
    logic [31:0]   in_pc0, in_pc1, in_npc0, in_npc1;
    logic [66:0]   in_dec0, in_dec1;
    logic          in_ready, out_valid, out_num;
    logic [31:0]   out_pc, out_npc;
    logic [66:0]   out_dec;
    logic          stop, flush;
    logic [3:0]    count;

    int vectors = 0;
    int miscompares = 0;
    bit proto_err = 0;

    fab_issue_queue #(.DEPTH(8), .PC_W(32), .DEC_W(67)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid0(in_valid0), .in_valid1(in_valid1),
        .in_pc0(in_pc0), .in_pc1(in_pc1), .in_npc0(in_npc0), .in_npc1(in_npc1),
        .in_dec0(in_dec0), .in_dec1(in_dec1), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_npc(out_npc),
        .out_dec(out_dec), .out_num(out_num),
        .stop(stop), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    // lane 1 without lane 0 is never legal
    always @(posedge clk) if (rst_n && in_valid1 && !in_valid0) proto_err = 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid0 = 0; in_valid1 = 0; flush = 0;
    endtask

    task automatic drive(input logic v0, input logic v1, input logic [31:0] pc0, input logic [31:0] pc1);
        in_valid0 = v0; in_valid1 = v1;
        in_pc0 = pc0; in_npc0 = pc0 + 32'd4;
        in_pc1 = pc1; in_npc1 = pc1 + 32'd4;
    endtask

    task automatic do_reset();
        idle_inputs(); stop = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs(); stop = 0;
        in_pc0 = 0; in_pc1 = 0; in_npc0 = 0; in_npc1 = 0; in_dec0 = 0; in_dec1 = 0;
        rst_n = 0;
        #2;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
        vectors++; if (out_num !== 1'b0) begin miscompares++; $display("FAIL reset_out_num got %b want 0", out_num); end
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_single();
        do_reset();
        drive(1, 0, 32'h100, 32'h0);
        in_dec0 = 67'h5_1234_5678_9ABC_DEF0;
        step();
        idle_inputs();
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", out_valid); end
        vectors++; if (out_pc !== 32'h100) begin miscompares++; $display("FAIL single_pc got %h want 100", out_pc); end
        vectors++; if (out_npc !== 32'h104) begin miscompares++; $display("FAIL single_npc got %h want 104", out_npc); end
        vectors++; if (out_dec !== 67'h5_1234_5678_9ABC_DEF0) begin miscompares++; $display("FAIL single_dec got %h want 5123456789abcdef0", out_dec); end
        vectors++; if (out_num !== 1'b0) begin miscompares++; $display("FAIL single_num got %b want 0", out_num); end
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL single_count got %0d want 1", count); end
        step();
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL single_pop_count got %0d want 0", count); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop_valid got %b want 0", out_valid); end
        vectors++; if (out_num !== 1'b1) begin miscompares++; $display("FAIL single_pop_num got %b want 1", out_num); end
    endtask

    task automatic test_dual_stop();
        do_reset();
        stop = 1;
        drive(1, 1, 32'h200, 32'h204);
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (out_pc !== 32'h200) begin miscompares++; $display("FAIL dual_hold_pc cycle %0d got %h want 200", i, out_pc); end
            vectors++; if (count !== 4'd2) begin miscompares++; $display("FAIL dual_hold_count cycle %0d got %0d want 2", i, count); end
            if (i < 2) step();
        end
        stop = 0;
        vectors++; if (out_num !== 1'b0) begin miscompares++; $display("FAIL dual_first_num got %b want 0", out_num); end
        step();
        vectors++; if (out_pc !== 32'h204) begin miscompares++; $display("FAIL dual_second_pc got %h want 204", out_pc); end
        vectors++; if (out_npc !== 32'h208) begin miscompares++; $display("FAIL dual_second_npc got %h want 208", out_npc); end
        vectors++; if (out_num !== 1'b1) begin miscompares++; $display("FAIL dual_second_num got %b want 1", out_num); end
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL dual_second_count got %0d want 1", count); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL dual_drain_valid got %b want 0", out_valid); end
    endtask

    task automatic test_full();
        do_reset();
        stop = 1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h500 + 32'(8 * i), 32'h504 + 32'(8 * i));
            step();
        end
        idle_inputs();
        vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL full_count got %0d want 8", count); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got %b want 0", in_ready); end
        drive(1, 1, 32'hDEAD0, 32'hDEAD4);
        step();
        idle_inputs();
        vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL full_drop_count got %0d want 8", count); end
        vectors++; if (out_pc !== 32'h500) begin miscompares++; $display("FAIL full_drop_head got %h want 500", out_pc); end
        stop = 0;
        step();
        vectors++; if (count !== 4'd7) begin miscompares++; $display("FAIL full_pop1_count got %0d want 7", count); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_pop1_ready got %b want 0", in_ready); end
        step();
        stop = 1;
        vectors++; if (count !== 4'd6) begin miscompares++; $display("FAIL full_pop2_count got %0d want 6", count); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL full_pop2_ready got %b want 1", in_ready); end
        vectors++; if (out_pc !== 32'h508) begin miscompares++; $display("FAIL full_pop2_head got %h want 508", out_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        stop = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'h600 + 32'(8 * i), 32'h604 + 32'(8 * i));
            step();
        end
        drive(1, 0, 32'h618, 32'h0);
        step();
        idle_inputs();
        vectors++; if (count !== 4'd7) begin miscompares++; $display("FAIL wrap_fill_count got %0d want 7", count); end
        stop = 0;
        for (int i = 0; i < 7; i++) step();
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL wrap_drain_count got %0d want 0", count); end
        stop = 1;
        drive(1, 1, 32'h300, 32'h304);
        step();
        idle_inputs();
        vectors++; if (out_pc !== 32'h300) begin miscompares++; $display("FAIL wrap_first_pc got %h want 300", out_pc); end
        stop = 0;
        step();
        vectors++; if (out_pc !== 32'h304) begin miscompares++; $display("FAIL wrap_second_pc got %h want 304", out_pc); end
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL wrap_second_count got %0d want 1", count); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_drain_valid got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 32'h0F0, 32'h0);
        step();
        idle_inputs();
        step();
        stop = 1;
        drive(1, 1, 32'h700, 32'h704); step();
        drive(1, 1, 32'h708, 32'h70C); step();
        drive(1, 0, 32'h710, 32'h0);   step();
        vectors++; if (count !== 4'd5) begin miscompares++; $display("FAIL flush_pre_count got %0d want 5", count); end
        stop = 0;
        drive(1, 1, 32'h800, 32'h804);
        flush = 1;
        step();
        idle_inputs();
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL flush_count got %0d want 0", count); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b want 0", out_valid); end
        vectors++; if (out_num !== 1'b1) begin miscompares++; $display("FAIL flush_num got %b want 1", out_num); end
        drive(1, 0, 32'h400, 32'h0);
        step();
        idle_inputs();
        vectors++; if (out_pc !== 32'h400) begin miscompares++; $display("FAIL flush_refetch_pc got %h want 400", out_pc); end
        vectors++; if (out_num !== 1'b1) begin miscompares++; $display("FAIL flush_refetch_num got %b want 1", out_num); end
        step();
        vectors++; if (out_num !== 1'b0) begin miscompares++; $display("FAIL flush_after_pop_num got %b want 0", out_num); end
    endtask

    task automatic test_async_reset();
        do_reset();
        stop = 1;
        drive(1, 1, 32'h900, 32'h904); step();
        drive(1, 0, 32'h908, 32'h0);   step();
        idle_inputs();
        vectors++; if (count !== 4'd3) begin miscompares++; $display("FAIL areset_pre_count got %0d want 3", count); end
        #2;
        rst_n = 0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid got %b want 0", out_valid); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL areset_count got %0d want 0", count); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL areset_ready got %b want 1", in_ready); end
        step();
        rst_n = 1;
        stop = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual_stop();
        test_full();
        test_wrap();
        test_flush();
        test_async_reset();
        vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL lane1_without_lane0 got %b want 0", proto_err); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
